// File: rtl/instruction_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_fetch_if : memory-read and instruction-handoff bundle          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface instruction_fetch_if;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_data;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        branch_en;
  logic [15:0] branch_target;
  logic        halt;

  // master: the fetch unit itself
  modport master (
    output mem_addr, mem_rd_en, ir, ir_pc, ir_valid,
    input  mem_rd_data, ir_ready, branch_en, branch_target, halt
  );

  // slave: memory plus control unit
  modport slave (
    input  mem_addr, mem_rd_en, ir, ir_pc, ir_valid,
    output mem_rd_data, ir_ready, branch_en, branch_target, halt
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_fetch : two-byte big-endian fetch into a valid/ready IR        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instruction_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          MEM_BYTES = 16384
) (
  input  wire                  clock,
  input  wire                  reset,
  instruction_fetch_if.master  bus
);

  localparam logic [15:0] c_ADDR_MASK = 16'(MEM_BYTES - 1);
  localparam logic [15:0] c_PC_MASK   = c_ADDR_MASK & 16'hFFFE;
  localparam logic [15:0] c_RESET_PC  = RESET_PC & c_PC_MASK;

  typedef enum logic [1:0] {
    S_REQ_HI = 2'd0,
    S_REQ_LO = 2'd1,
    S_CAP_LO = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [7:0]  r_hi;
  logic [15:0] r_ir;
  logic [15:0] r_ir_pc;
  logic        r_ir_valid;

  logic [15:0] w_mem_addr;
  logic        w_mem_rd_en;

  // pc is always aligned, so pc+1 never crosses the wrap boundary
  assign w_mem_addr  = (r_state == S_REQ_LO) ? ((r_pc + 16'd1) & c_ADDR_MASK) : r_pc;
  assign w_mem_rd_en = !reset && !bus.branch_en &&
                       (((r_state == S_REQ_HI) && !bus.halt) || (r_state == S_REQ_LO));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_REQ_HI;
      r_pc       <= c_RESET_PC;
      r_hi       <= 8'h00;
      r_ir       <= 16'h0000;
      r_ir_pc    <= 16'h0000;
      r_ir_valid <= 1'b0;
    end else if (bus.branch_en) begin
      r_pc       <= bus.branch_target & c_PC_MASK;
      r_ir_valid <= 1'b0;
      r_state    <= S_REQ_HI;
    end else begin
      case (r_state)
        S_REQ_HI: begin
          if (!bus.halt) r_state <= S_REQ_LO;
        end
        S_REQ_LO: begin
          r_hi    <= bus.mem_rd_data;
          r_state <= S_CAP_LO;
        end
        S_CAP_LO: begin
          r_ir       <= {r_hi, bus.mem_rd_data};
          r_ir_pc    <= r_pc;
          r_ir_valid <= 1'b1;
          r_pc       <= (r_pc + 16'd2) & c_PC_MASK;
          r_state    <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.ir_ready) begin
            r_ir_valid <= 1'b0;
            r_state    <= S_REQ_HI;
          end
        end
        default: r_state <= S_REQ_HI;
      endcase
    end
  end

  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_rd_en = w_mem_rd_en;
  assign bus.ir        = r_ir;
  assign bus.ir_pc     = r_ir_pc;
  assign bus.ir_valid  = r_ir_valid;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instruction_fetch : directed and random checks against a fetch model    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch;
  localparam int          c_MEM_BYTES = 16384;
  localparam logic [15:0] c_MASK      = 16'(c_MEM_BYTES - 1);
  localparam logic [15:0] c_RESET_PC  = 16'h0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_if bus();

  instruction_fetch #(.RESET_PC(c_RESET_PC), .MEM_BYTES(c_MEM_BYTES)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  logic [7:0] mem [0:c_MEM_BYTES-1];
  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  // byte memory with one-cycle registered read
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[int'(bus.mem_addr & c_MASK)];
  end

  // model: pc, how far into the current instruction we are, and the held word
  logic [15:0] m_pc, m_ir, m_ir_pc;
  logic        m_valid;
  int          m_step;   // 0 waiting to start, 1 hi byte asked, 2 lo byte asked, 3 holding

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= c_RESET_PC & 16'hFFFE; m_step <= 0; m_valid <= 1'b0;
      m_ir <= 16'h0; m_ir_pc <= 16'h0;
    end else if (bus.branch_en) begin
      m_pc <= bus.branch_target & c_MASK & 16'hFFFE; m_step <= 0; m_valid <= 1'b0;
    end else if (m_step == 0) begin
      if (!bus.halt) m_step <= 1;
    end else if (m_step == 1) begin
      m_step <= 2;
    end else if (m_step == 2) begin
      m_ir    <= {mem[int'(m_pc)], mem[int'((m_pc + 16'd1) & c_MASK)]};
      m_ir_pc <= m_pc;
      m_pc    <= 16'((int'(m_pc) + 2) % c_MEM_BYTES);
      m_valid <= 1'b1;
      m_step  <= 3;
    end else if (bus.ir_ready) begin
      m_valid <= 1'b0; m_step <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_rd_en", 32'(bus.mem_rd_en),
          32'(!rst && !bus.branch_en && ((m_step == 0 && !bus.halt) || m_step == 1)));
      chk("mdl_addr", 32'(bus.mem_addr), 32'((m_step == 1) ? ((m_pc + 16'd1) & c_MASK) : m_pc));
      chk("mdl_valid", 32'(bus.ir_valid), 32'(m_valid));
      chk("mdl_ir", 32'(bus.ir), 32'(m_ir));
      chk("mdl_ir_pc", 32'(bus.ir_pc), 32'(m_ir_pc));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step(); rst = 1'b1;
    step(); step(); rst = 1'b0;
  endtask

  // counts negedges until ir_valid is seen, bounded
  task automatic wait_rise(output int n);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); n++;
      if (bus.ir_valid) break;
    end
  endtask

  int n;

  initial begin
    for (int i = 0; i < c_MEM_BYTES; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    mem[16'h0100] = 8'hC3; mem[16'h0101] = 8'h5A;
    mem[16382] = 8'hAB; mem[16383] = 8'hCD;
    bus.ir_ready = 1'b1; bus.branch_en = 1'b0; bus.branch_target = 16'h0; bus.halt = 1'b0;

    // back-to-back fetch with ready held high
    do_reset();
    chk_en = 1'b1;
    wait_rise(n);
    chk("t1_lat", 32'(n), 32'd4);
    chk("t1_ir0", 32'(bus.ir), 32'h1234);
    chk("t1_pc0", 32'(bus.ir_pc), 32'h0);
    wait_rise(n);
    chk("t1_gap", 32'(n), 32'd4);
    chk("t1_ir1", 32'(bus.ir), 32'h5678);
    chk("t1_pc1", 32'(bus.ir_pc), 32'h2);

    // hold while not ready
    bus.ir_ready = 1'b0;
    do_reset();
    wait_rise(n);
    chk("t2_lat", 32'(n), 32'd4);
    for (int i = 0; i < 10; i++) begin
      step(); @(negedge clk);
      chk("t2_valid", 32'(bus.ir_valid), 32'd1);
      chk("t2_ir", 32'(bus.ir), 32'h1234);
      chk("t2_rd_en", 32'(bus.mem_rd_en), 32'd0);
    end

    // branch during REQ_LO, then branch plus handshake during HOLD
    do_reset();
    step(); bus.branch_en = 1'b1; bus.branch_target = 16'h0101;
    @(negedge clk);
    chk("t3_rd_en_br", 32'(bus.mem_rd_en), 32'd0);
    step(); bus.branch_en = 1'b0;
    @(negedge clk);
    chk("t3_addr_hi", 32'(bus.mem_addr), 32'h0100);
    chk("t3_rd_hi", 32'(bus.mem_rd_en), 32'd1);
    chk("t3_valid0", 32'(bus.ir_valid), 32'd0);
    step(); @(negedge clk);
    chk("t3_addr_lo", 32'(bus.mem_addr), 32'h0101);
    chk("t3_valid1", 32'(bus.ir_valid), 32'd0);
    step(); @(negedge clk);
    chk("t3_valid2", 32'(bus.ir_valid), 32'd0);
    step(); bus.branch_en = 1'b1; bus.branch_target = 16'h0200; bus.ir_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_hold", 32'(bus.ir_valid), 32'd1);
    chk("t4_ir", 32'(bus.ir), 32'hC35A);
    chk("t4_ir_pc", 32'(bus.ir_pc), 32'h0100);
    step(); bus.branch_en = 1'b0;
    @(negedge clk);
    chk("t4_valid_after", 32'(bus.ir_valid), 32'd0);
    chk("t4_addr", 32'(bus.mem_addr), 32'h0200);

    // wrap at the top of memory
    step(); bus.branch_en = 1'b1; bus.branch_target = 16'd16382;
    step(); bus.branch_en = 1'b0;
    wait_rise(n);
    chk("t5_lat", 32'(n), 32'd4);
    chk("t5_ir", 32'(bus.ir), 32'hABCD);
    chk("t5_ir_pc", 32'(bus.ir_pc), 32'd16382);
    chk("t5_addr_hold", 32'(bus.mem_addr), 32'h0);
    step(); @(negedge clk);
    chk("t5_addr_next", 32'(bus.mem_addr), 32'h0);
    chk("t5_rd_next", 32'(bus.mem_rd_en), 32'd1);

    // halt from reset, then reset during CAP_LO
    bus.halt = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_halt_rd", 32'(bus.mem_rd_en), 32'd0);
      chk("t6_halt_valid", 32'(bus.ir_valid), 32'd0);
      step();
    end
    bus.halt = 1'b0;
    wait_rise(n);
    chk("t6_lat", 32'(n), 32'd4);
    chk("t6_ir", 32'(bus.ir), 32'h1234);
    step(); step(); step(); rst = 1'b1;
    step(); @(negedge clk);
    chk("t6_rst_valid", 32'(bus.ir_valid), 32'd0);
    chk("t6_rst_ir", 32'(bus.ir), 32'h0);
    chk("t6_rst_ir_pc", 32'(bus.ir_pc), 32'h0);
    chk("t6_rst_addr", 32'(bus.mem_addr), 32'(c_RESET_PC));
    chk("t6_rst_rd", 32'(bus.mem_rd_en), 32'd0);
    step(); rst = 1'b0;

    // random traffic, checked every cycle by the model compare
    for (int i = 0; i < 3000; i++) begin
      step();
      rst               = ($urandom_range(0, 199) == 0);
      bus.branch_en     = ($urandom_range(0, 19) == 0);
      bus.branch_target = 16'($urandom);
      bus.halt          = ($urandom_range(0, 4) == 0);
      bus.ir_ready      = ($urandom_range(0, 1) == 0);
    end
    step(); rst = 1'b0; bus.branch_en = 1'b0; bus.halt = 1'b0;
    step(); step();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
